// File: rtl/draw_layer_scheduler_pkg.sv
// Shared definitions for the draw layer scheduler: field widths, state encoding,
// default engine-accept timeout and a saturating counter helper.
package draw_layer_scheduler_pkg;

  localparam int X_W             = 8;
  localparam int Y_W             = 9;
  localparam int ROM_W           = 4;
  localparam int IDX_W           = 2;
  localparam int CNT_W           = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECT    = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SELECT    = ST_SELECT,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_FINISH    = ST_FINISH
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/draw_layer_scheduler_priority.sv
// Lowest-set-bit priority encoder used to pick the next layer to draw.
module layer_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o,
  output logic [N-1:0]     onehot_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    index_o = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        valid_o = 1'b1;
        index_o = IDX_W'(i);
      end else begin
        valid_o = valid_o;
      end
    end
  end

  assign onehot_o = mask_i & (~mask_i + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/draw_layer_scheduler.sv
// Per-frame scheduler that issues enabled draw layers bottom-up to a draw engine,
// using a snapshot of the layer configuration taken at frameTick.
module draw_layer_scheduler
  import draw_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int ACCEPT_TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frameTick,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [X_W*NUM_LAYERS-1:0]   xOriginIn,
  input  logic [Y_W*NUM_LAYERS-1:0]   yOriginIn,
  input  logic [ROM_W*NUM_LAYERS-1:0] romIdIn,
  input  logic                        drawReady,
  output logic                        draw,
  output logic [X_W-1:0]              xOrigin,
  output logic [Y_W-1:0]              yOrigin,
  output logic [ROM_W-1:0]            ROMId,
  output logic [IDX_W-1:0]            layerIndex,
  output logic                        busy,
  output logic                        frameDone,
  output logic                        frameOverrun,
  output logic                        timeoutError
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(ACCEPT_TIMEOUT);

  state_e                      state_q;
  logic [NUM_LAYERS-1:0]       mask_q;
  logic [X_W*NUM_LAYERS-1:0]   x_shadow_q;
  logic [Y_W*NUM_LAYERS-1:0]   y_shadow_q;
  logic [ROM_W*NUM_LAYERS-1:0] rom_shadow_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        timeout_hit_d;

  logic                        draw_q;
  logic [X_W-1:0]              x_q;
  logic [Y_W-1:0]              y_q;
  logic [ROM_W-1:0]            rom_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        overrun_q;
  logic                        timeout_q;

  logic                        sel_valid;
  logic [IDX_W-1:0]            sel_idx;
  logic [NUM_LAYERS-1:0]       sel_onehot;

  layer_priority_select #(
    .N     (NUM_LAYERS),
    .IDX_W (IDX_W)
  ) u_select (
    .mask_i   (mask_q),
    .valid_o  (sel_valid),
    .index_o  (sel_idx),
    .onehot_o (sel_onehot)
  );

  assign cnt_d         = sat_inc(cnt_q);
  assign timeout_hit_d = (cnt_d >= TIMEOUT_LIM);

  // Frame sequencing; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= {NUM_LAYERS{1'b0}};
      x_shadow_q   <= {(X_W*NUM_LAYERS){1'b0}};
      y_shadow_q   <= {(Y_W*NUM_LAYERS){1'b0}};
      rom_shadow_q <= {(ROM_W*NUM_LAYERS){1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      draw_q       <= 1'b0;
      x_q          <= {X_W{1'b0}};
      y_q          <= {Y_W{1'b0}};
      rom_q        <= {ROM_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= frameTick && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (frameTick) begin
            mask_q       <= layerEnable;
            x_shadow_q   <= xOriginIn;
            y_shadow_q   <= yOriginIn;
            rom_shadow_q <= romIdIn;
            busy_q       <= 1'b1;
            state_q      <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (sel_valid) begin
            x_q     <= x_shadow_q[int'(sel_idx)*X_W +: X_W];
            y_q     <= y_shadow_q[int'(sel_idx)*Y_W +: Y_W];
            rom_q   <= rom_shadow_q[int'(sel_idx)*ROM_W +: ROM_W];
            idx_q   <= sel_idx;
            mask_q  <= mask_q & ~sel_onehot;
            cnt_q   <= {CNT_W{1'b0}};
            draw_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_FINISH;
          end
        end
        S_ISSUE: begin
          if (!drawReady) begin
            draw_q  <= 1'b0;
            state_q <= S_WAIT_DONE;
          end else if (timeout_hit_d) begin
            // Engine never accepted: flag it and drop the rest of the frame.
            timeout_q <= 1'b1;
            draw_q    <= 1'b0;
            mask_q    <= {NUM_LAYERS{1'b0}};
            state_q   <= S_FINISH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (drawReady) begin
            state_q <= S_SELECT;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          draw_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign draw         = draw_q;
  assign xOrigin      = x_q;
  assign yOrigin      = y_q;
  assign ROMId        = rom_q;
  assign layerIndex   = idx_q;
  assign busy         = busy_q;
  assign frameDone    = done_q;
  assign frameOverrun = overrun_q;
  assign timeoutError = timeout_q;

endmodule

// File: tb/tb_draw_layer_scheduler.sv
// Directed bench for draw_layer_scheduler: engine model, draw scoreboard, latency
// and error-path checks.
module tb_draw_layer_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        frameTick;
  logic [3:0]  layerEnable;
  logic [31:0] xOriginIn;
  logic [35:0] yOriginIn;
  logic [15:0] romIdIn;
  logic        drawReady = 1'b1;
  logic        draw;
  logic [7:0]  xOrigin;
  logic [8:0]  yOrigin;
  logic [3:0]  ROMId;
  logic [1:0]  layerIndex;
  logic        busy, frameDone, frameOverrun, timeoutError;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] x;
    logic [8:0] y;
    logic [3:0] rom;
  } draw_t;
  draw_t exp_q[$];

  logic eng_stuck = 1'b0;
  int   eng_cnt   = 0;
  logic prev_draw = 1'b0;

  draw_layer_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .frameTick    (frameTick),
    .layerEnable  (layerEnable),
    .xOriginIn    (xOriginIn),
    .yOriginIn    (yOriginIn),
    .romIdIn      (romIdIn),
    .drawReady    (drawReady),
    .draw         (draw),
    .xOrigin      (xOrigin),
    .yOrigin      (yOrigin),
    .ROMId        (ROMId),
    .layerIndex   (layerIndex),
    .busy         (busy),
    .frameDone    (frameDone),
    .frameOverrun (frameOverrun),
    .timeoutError (timeoutError)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Draw engine: accepts a request, stays busy 10 cycles; when stuck it never accepts.
  always @(posedge clock) begin
    if (eng_stuck) begin
      drawReady <= 1'b1;
      eng_cnt   <= 0;
    end else if (drawReady && draw) begin
      drawReady <= 1'b0;
      eng_cnt   <= 10;
    end else if (!drawReady) begin
      if (eng_cnt <= 1) drawReady <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  // Scoreboard: each rising draw must match the next expected layer.
  always @(negedge clock) begin
    if (draw && !prev_draw) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_draw", {30'd0, layerIndex}, 32'hFFFF_FFFF);
      end else begin
        draw_t e;
        e = exp_q.pop_front();
        chk("draw_layerIndex", {30'd0, layerIndex}, {30'd0, e.idx});
        chk("draw_xOrigin",    {24'd0, xOrigin},    {24'd0, e.x});
        chk("draw_yOrigin",    {23'd0, yOrigin},    {23'd0, e.y});
        chk("draw_ROMId",      {28'd0, ROMId},      {28'd0, e.rom});
      end
    end
    prev_draw = draw;
  end

  // Drives one frameTick; push_limit caps how many layers are expected to be drawn.
  task automatic start_frame(input logic [3:0] en, input logic [31:0] x, input logic [35:0] y,
                             input logic [15:0] rom, input int push_limit);
    int pushed = 0;
    @(posedge clock); #1;
    layerEnable = en; xOriginIn = x; yOriginIn = y; romIdIn = rom;
    frameTick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && pushed < push_limit) begin
        exp_q.push_back('{idx: 2'(i), x: x[8*i +: 8], y: y[9*i +: 9], rom: rom[4*i +: 4]});
        pushed++;
      end
    end
    @(posedge clock); #1;
    frameTick = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (frameDone) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(negedge clock);
      chk({tag, "_done_one_cycle"}, {31'd0, frameDone}, 32'd0);
    end
    chk({tag, "_all_drawn"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int draw_cycles;
    bit found;
    reset = 1'b1; frameTick = 1'b0; layerEnable = 4'd0;
    xOriginIn = 32'd0; yOriginIn = 36'd0; romIdIn = 16'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_draw", {31'd0, draw}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, frameDone, frameOverrun, timeoutError}, 32'd0);
    chk("rst_fields", {9'd0, xOrigin, yOrigin, ROMId, layerIndex}, 32'd0);

    // All four layers, with draw latency check.
    start_frame(4'b1111, 32'h4030_2010, {9'h1F3, 9'h0A2, 9'h155, 9'h001}, 16'hDCBA, 4);
    @(negedge clock);
    chk("f1_busy_next", {31'd0, busy}, 32'd1);
    chk("f1_draw_not_yet", {31'd0, draw}, 32'd0);
    @(negedge clock);
    chk("f1_draw_latency2", {31'd0, draw}, 32'd1);
    wait_done("f1", 200);

    // Sparse enable: only layers 1 and 3.
    start_frame(4'b1010, 32'hA1B2_C3D4, {9'h111, 9'h022, 9'h133, 9'h044}, 16'h5678, 4);
    wait_done("f2", 200);

    // Empty frame: frameDone three cycles after the tick, no draw.
    start_frame(4'b0000, 32'h1111_1111, 36'h0, 16'h0, 4);
    @(negedge clock);
    chk("f3_done_c1", {30'd0, frameDone, draw}, 32'd0);
    @(negedge clock);
    chk("f3_done_c2", {30'd0, frameDone, draw}, 32'd0);
    @(negedge clock);
    chk("f3_done_c3", {30'd0, frameDone, draw}, 32'd2);
    @(negedge clock);
    chk("f3_idle_after", {30'd0, frameDone, busy}, 32'd0);

    // Overrun during layer 2 WAIT_DONE plus mid-frame origin change.
    start_frame(4'b1111, 32'h8877_6655, {9'h0F0, 9'h0E0, 9'h0D0, 9'h0C0}, 16'h4321, 4);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (busy && layerIndex == 2'd2 && !draw && !drawReady) found = 1'b1;
    end
    chk("f4_reached_l2_wait", {31'd0, found}, 32'd1);
    @(posedge clock); #1;
    frameTick = 1'b1; xOriginIn = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    frameTick = 1'b0;
    @(negedge clock);
    chk("f4_overrun_pulse", {31'd0, frameOverrun}, 32'd1);
    @(negedge clock);
    chk("f4_overrun_clear", {31'd0, frameOverrun}, 32'd0);
    wait_done("f4", 200);
    repeat (5) @(negedge clock);
    chk("f4_no_extra_frame", {31'd0, busy}, 32'd0);

    // Engine never accepts: layer 0 times out, layer 1 is abandoned.
    eng_stuck = 1'b1;
    start_frame(4'b0011, 32'h0000_2233, {9'h0, 9'h0, 9'h0AA, 9'h055}, 16'h0076, 1);
    draw_cycles = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (draw) draw_cycles++;
      if (frameDone) found = 1'b1;
    end
    chk("f5_done_seen", {31'd0, found}, 32'd1);
    chk("f5_issue_cycles", draw_cycles, 32'd255);
    chk("f5_timeout_set", {31'd0, timeoutError}, 32'd1);
    chk("f5_busy_clear", {31'd0, busy}, 32'd0);
    eng_stuck = 1'b0;
    repeat (2) @(negedge clock);

    // Next frame runs normally, error stays sticky.
    start_frame(4'b0100, 32'h0099_0000, {9'h0, 9'h1AB, 9'h0, 9'h0}, 16'h0E00, 4);
    wait_done("f6", 200);
    chk("f6_timeout_sticky", {31'd0, timeoutError}, 32'd1);

    // Reset while in ISSUE aborts with no frameDone.
    eng_stuck = 1'b1;
    start_frame(4'b0001, 32'h0000_0042, {27'd0, 9'h033}, 16'h0009, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (draw) found = 1'b1;
    end
    chk("f7_in_issue", {31'd0, found}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("f7_rst_draw", {31'd0, draw}, 32'd0);
    chk("f7_rst_busy", {31'd0, busy}, 32'd0);
    chk("f7_rst_timeout_clr", {31'd0, timeoutError}, 32'd0);
    draw_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (frameDone) draw_cycles++;
      @(negedge clock);
    end
    chk("f7_no_done_pulse", draw_cycles, 32'd0);
    eng_stuck = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
